// File: rtl/if_fetch.sv
// Instruction fetch stage: one-cycle-latency ROM fetch with ready/valid hand-off, redirect and stall.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [10:0] imem_addr,
    input  logic [31:0] imem_douta,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_trap
);

    logic [31:0] pc_q;
    logic [31:0] resp_pc_q;
    logic [31:0] fetch_addr;
    logic        valid_q;
    logic        trap_q;
    logic        halt_q;
    logic        trap_redir;
    logic        issue;
    logic        fire;

`ifdef IF_MISALIGN_TRAP_EN
    assign trap_redir = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign fetch_addr = redirect_valid ? redirect_pc : pc_q;

    // A trap response parks the stage until the next redirect restarts fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
            trap_q <= 1'b0;
        end else if (trap_redir) begin
            halt_q <= 1'b1;
            trap_q <= 1'b1;
        end else if (issue) begin
            halt_q <= 1'b0;
            trap_q <= 1'b0;
        end else if (fire) begin
            trap_q <= 1'b0;
        end
    end

    assign out_inst = trap_q ? 32'h0000_0013 : imem_douta;
`else
    assign trap_redir = 1'b0;
    assign trap_q     = 1'b0;
    assign halt_q     = 1'b0;
    assign fetch_addr = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_q;
    assign out_inst   = imem_douta;
`endif

    // A redirect always restarts fetch, even out of a trap halt.
    assign issue     = rst_n & (redirect_valid | (~halt_q & (~valid_q | out_ready)));
    assign imem_en   = issue & ~trap_redir;
    assign imem_addr = fetch_addr[12:2];

    assign out_valid = valid_q & ~redirect_valid;
    assign fire      = out_valid & out_ready;
    assign out_pc    = resp_pc_q;
    assign out_trap  = trap_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            valid_q   <= 1'b0;
        end else if (trap_redir) begin
            resp_pc_q <= redirect_pc;
            valid_q   <= 1'b1;
        end else if (issue) begin
            resp_pc_q <= fetch_addr;
            pc_q      <= fetch_addr + 32'd4;
            valid_q   <= 1'b1;
        end else if (fire) begin
            valid_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: stream-level reference model, directed scenarios plus random traffic.
module tb_if_fetch;

`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [10:0] imem_addr;
    logic [31:0] imem_douta;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_trap;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_douta(imem_douta), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_trap(out_trap)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:2047];
    always @(posedge clk) if (imem_en) imem_douta <= rom[imem_addr];

    typedef struct packed {
        logic        v;
        logic        en;
        logic [10:0] addr;
    } cyc_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        trap;
    } item_t;

    cyc_t  cyc_q [$];
    item_t fire_q [$];
    int    errors = 0;
    int    checks = 0;

    // Stream model: what the decode side should be looking at, and where fetch continues.
    bit          m_show = 1'b0;
    logic [31:0] m_pc = RST_PC;
    bit          m_trap = 1'b0;
    logic [31:0] m_fetch = RST_PC;
    bit          m_halt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit          mis;
        bit          ev;
        bit          een;
        logic [31:0] ft;
        cyc_t        c;
        item_t       it;
        @(posedge clk);
        #1;
        rst_n = rst; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        mis = TRAP && rv && (rpc[1:0] != 2'b00);
        ft  = rv ? (rpc & 32'hFFFF_FFFC) : m_fetch;
        ev  = m_show && !rv;
        een = rst && !mis && (rv || (!m_halt && (!m_show || rdy)));
        c.v = ev; c.en = een; c.addr = ft[12:2];
        cyc_q.push_back(c);
        if (ev && rdy) begin
            it.pc   = m_pc;
            it.trap = m_trap;
            it.inst = m_trap ? 32'h0000_0013 : rom[m_pc[12:2]];
            fire_q.push_back(it);
        end
        if (!rst) begin
            m_show = 0; m_fetch = RST_PC; m_halt = 0; m_trap = 0;
        end else if (mis) begin
            m_show = 1; m_pc = rpc; m_trap = 1; m_halt = 1;
        end else if (een) begin
            m_show = 1; m_pc = ft; m_fetch = ft + 32'd4; m_trap = 0; m_halt = 0;
        end else if (ev && rdy) begin
            m_show = 0; m_trap = 0;
        end
    endtask

    // Monitor: per-cycle handshake checks and in-order delivery checks on every fire.
    initial begin
        cyc_t  c;
        item_t it;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("out_valid", {31'd0, out_valid}, {31'd0, c.v});
                check("imem_en", {31'd0, imem_en}, {31'd0, c.en});
                if (c.en) check("imem_addr", {21'd0, imem_addr}, {21'd0, c.addr});
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (fire_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fire: got pc %h expected no delivery", out_pc);
                end else begin
                    it = fire_q.pop_front();
                    check("out_pc", out_pc, it.pc);
                    check("out_inst", out_inst, it.inst);
                    check("out_trap", {31'd0, out_trap}, {31'd0, it.trap});
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 2048; i++) rom[i] = $urandom;

        // reset, then streaming from RESET_PC with a 3-cycle stall on 0x8
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        // stalled on 0x10, redirect to 0x100 kills it
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 32'h100);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        // 8 KiB ROM wrap and 32-bit address wrap
        cyc(1, 1, 1, 32'h1FF8);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        // back-to-back redirects, only the last delivered
        cyc(1, 1, 1, 32'h40); cyc(1, 1, 1, 32'h80); cyc(1, 1, 1, 32'hC0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        // misaligned redirect, then resume at 0x200
        cyc(1, 1, 1, 32'h102);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'h200); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        // misaligned redirect held by back-pressure
        cyc(1, 1, 1, 32'h307); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 1, 32'h400); cyc(1, 1, 0, 0);
        // reset during a stall
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rpc = $urandom;
                1: rpc = {19'd0, $urandom_range(0, 8191)} & 32'h1FFC;
                2: rpc = 32'h1FF0 + ($urandom_range(0, 3) * 4);
                default: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0, rpc);
        end
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);

        @(negedge clk);
        #1;
        check("pending_deliveries", fire_q.size(), 0);
        check("pending_cycles", cyc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
